// File: rtl/ppm_frame_scheduler_pkg.sv
// Shared constants, state encoding and slot-width helper for the PPM frame scheduler.
package ppm_pkg;

  typedef logic [1:0] chan_t;

  localparam chan_t CH_ROLL  = 2'd0;
  localparam chan_t CH_PITCH = 2'd1;
  localparam chan_t CH_THR   = 2'd2;
  localparam chan_t CH_YAW   = 2'd3;

  localparam logic [7:0] NEUTRAL  = 8'd116;
  localparam logic [7:0] THR_SAFE = 8'd0;

  localparam int SLOT_MIN_US  = 1000;
  localparam int SLOT_STEP_US = 4;
  localparam int V_CLAMP      = 250;

  typedef enum logic [1:0] {
    SEP,
    CHAN,
    END_SEP,
    SYNC
  } state_t;

  // Full slot width in us; clamping keeps the 12-bit result within 1000..2000.
  function automatic logic [11:0] slot_width(input logic [7:0] v);
    logic [7:0] vc;
    vc = (v > 8'(V_CLAMP)) ? 8'(V_CLAMP) : v;
    return 12'(SLOT_MIN_US) + 12'(SLOT_STEP_US) * {4'd0, vc};
  endfunction

endpackage

// File: rtl/ppm_frame_scheduler_if.sv
// Command inputs from the axis blocks and the PPM-side outputs of the scheduler.
interface ppm_frame_scheduler_if;
  import ppm_pkg::*;

  logic [7:0] roll_mag;
  logic [7:0] pitch_mag;
  logic [7:0] yaw_mag;
  logic [7:0] thr_mag;
  logic       track_valid;
  logic       ppm_out;
  logic       frame_start;
  chan_t      chan_idx;
  logic       failsafe;

  modport master (
    output roll_mag, pitch_mag, yaw_mag, thr_mag, track_valid,
    input  ppm_out, frame_start, chan_idx, failsafe
  );

  modport slave (
    input  roll_mag, pitch_mag, yaw_mag, thr_mag, track_valid,
    output ppm_out, frame_start, chan_idx, failsafe
  );
endinterface

// File: rtl/ppm_frame_scheduler_us_tick_gen.sv
// Microsecond prescaler: one-cycle tick on the last clock of every CLK_PER_US-cycle period.
module us_tick_gen #(
  parameter int CLK_PER_US = 65
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);

  logic [PW-1:0] pre_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_reg <= '0;
    end else if (en) begin
      pre_reg <= (pre_reg == PRE_MAX) ? '0 : pre_reg + PW'(1);
    end
  end

  assign tick = en && (pre_reg == PRE_MAX);

endmodule

// File: rtl/ppm_frame_scheduler.sv
// Latches one command set per frame and emits it as a four-channel PPM train,
// substituting safe values after a run of frames without hand tracking.
module ppm_frame_scheduler
  import ppm_pkg::*;
#(
  parameter int         CLK_PER_US = 65,
  parameter int         FRAME_US   = 20000,
  parameter int         SEP_US     = 300,
  parameter logic [7:0] NEUTRAL    = ppm_pkg::NEUTRAL,
  parameter logic [7:0] THR_SAFE   = ppm_pkg::THR_SAFE,
  parameter int         FS_FRAMES  = 25
) (
  input logic                  clock,
  input logic                  reset,
  ppm_frame_scheduler_if.slave bus
);

  localparam int FW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int CW = $clog2(FS_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_US - 1);
  localparam logic [11:0]   SEP_LEN    = 12'(SEP_US);
  localparam logic [11:0]   SEP_LAST   = 12'(SEP_US - 1);
  localparam logic [CW-1:0] FS_MAX     = CW'(FS_FRAMES);

  state_t          state_reg, state_next;
  chan_t           chan_reg, chan_next;
  logic [11:0]     slot_cnt_reg, slot_cnt_next;
  logic [FW-1:0]   frame_cnt_reg, frame_cnt_next;
  logic            pending_reg;
  logic            frame_start_reg, frame_start_next;
  logic [CW-1:0]   fs_cnt_reg, fs_cnt_next;
  logic            failsafe_reg, failsafe_next;
  logic [3:0][7:0] live;
  logic [3:0][7:0] lat;
  logic [11:0]     chan_last;
  logic            tick;

  // Timebase is held at phase zero until the first frame starts, so every
  // frame begins exactly on a prescaler boundary.
  us_tick_gen #(
    .CLK_PER_US(CLK_PER_US)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .en   (!pending_reg),
    .tick (tick)
  );

  always_comb begin
    live           = '0;
    live[CH_ROLL]  = bus.roll_mag;
    live[CH_PITCH] = bus.pitch_mag;
    live[CH_THR]   = bus.thr_mag;
    live[CH_YAW]   = bus.yaw_mag;
  end

  assign chan_last = slot_width(lat[chan_reg]) - SEP_LEN - 12'd1;

  always_comb begin
    state_next       = state_reg;
    chan_next        = chan_reg;
    slot_cnt_next    = slot_cnt_reg;
    frame_cnt_next   = frame_cnt_reg;
    frame_start_next = 1'b0;
    if (pending_reg) begin
      state_next       = SEP;
      chan_next        = CH_ROLL;
      slot_cnt_next    = '0;
      frame_cnt_next   = '0;
      frame_start_next = 1'b1;
    end else if (tick) begin
      frame_cnt_next = frame_cnt_reg + FW'(1);
      case (state_reg)
        SEP: begin
          slot_cnt_next = slot_cnt_reg + 12'd1;
          if (slot_cnt_reg == SEP_LAST) begin
            state_next    = CHAN;
            slot_cnt_next = '0;
          end
        end
        CHAN: begin
          slot_cnt_next = slot_cnt_reg + 12'd1;
          if (slot_cnt_reg == chan_last) begin
            slot_cnt_next = '0;
            if (chan_reg == CH_YAW) begin
              state_next = END_SEP;
            end else begin
              state_next = SEP;
              chan_next  = chan_reg + 2'd1;
            end
          end
        end
        END_SEP: begin
          slot_cnt_next = slot_cnt_reg + 12'd1;
          if (slot_cnt_reg == SEP_LAST) begin
            state_next    = SYNC;
            slot_cnt_next = '0;
          end
        end
        SYNC: begin
          if (frame_cnt_reg == FRAME_LAST) begin
            state_next       = SEP;
            chan_next        = CH_ROLL;
            frame_cnt_next   = '0;
            frame_start_next = 1'b1;
          end
        end
        default: state_next = SEP;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= SEP;
      chan_reg        <= CH_ROLL;
      slot_cnt_reg    <= '0;
      frame_cnt_reg   <= '0;
      pending_reg     <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      chan_reg        <= chan_next;
      slot_cnt_reg    <= slot_cnt_next;
      frame_cnt_reg   <= frame_cnt_next;
      pending_reg     <= 1'b0;
      frame_start_reg <= frame_start_next;
    end
  end

  // The latch below consumes failsafe_next, so recovery applies to the very
  // frame in which tracking is seen again.
  always_comb begin
    if (bus.track_valid) begin
      fs_cnt_next = '0;
    end else if (fs_cnt_reg == FS_MAX) begin
      fs_cnt_next = fs_cnt_reg;
    end else begin
      fs_cnt_next = fs_cnt_reg + CW'(1);
    end
    failsafe_next = (fs_cnt_next == FS_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fs_cnt_reg   <= '0;
      failsafe_reg <= 1'b0;
    end else if (frame_start_reg) begin
      fs_cnt_reg   <= fs_cnt_next;
      failsafe_reg <= failsafe_next;
    end
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lat
    localparam logic [7:0] SAFE_V = (gi == int'(CH_THR)) ? THR_SAFE : NEUTRAL;
    logic [7:0] val_reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        val_reg <= SAFE_V;
      end else if (frame_start_reg) begin
        val_reg <= failsafe_next ? SAFE_V : live[gi];
      end
    end

    assign lat[gi] = val_reg;
  end

  assign bus.ppm_out     = pending_reg || (state_reg == CHAN) || (state_reg == SYNC);
  assign bus.frame_start = frame_start_reg;
  assign bus.chan_idx    = chan_reg;
  assign bus.failsafe    = failsafe_reg;

endmodule

// File: tb/tb_ppm_frame_scheduler.sv
// Scoreboard bench: stimulus queues the expected slot widths per frame, a monitor measures the PPM train.
module tb_ppm_frame_scheduler;
  import ppm_pkg::*;

  localparam int CLK_PER_US = 2;
  localparam int FRAME_US   = 20000;
  localparam int SEP_US     = 300;
  localparam int FRAME_CLK  = CLK_PER_US * FRAME_US;

  typedef struct packed {
    logic [3:0][11:0] w;
    logic             fs;
  } frame_exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ppm_frame_scheduler_if bus ();

  ppm_frame_scheduler #(
    .CLK_PER_US(CLK_PER_US),
    .FRAME_US  (FRAME_US),
    .SEP_US    (SEP_US),
    .NEUTRAL   (8'd116),
    .THR_SAFE  (8'd0),
    .FS_FRAMES (25)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  frame_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int         mon_cyc;
  int         mon_last_fall;
  int         mon_nfall;
  int         mon_frame_no;
  bit         mon_in_frame;
  logic       mon_prev_ppm;
  frame_exp_t mon_cur;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic abort(input string tag);
    checks++;
    errors++;
    $display("FAIL timeout %s: got no event, expected one within the cycle budget", tag);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic set_in(input int r, input int p, input int t, input int y, input bit tv);
    bus.roll_mag    = 8'(r);
    bus.pitch_mag   = 8'(p);
    bus.thr_mag     = 8'(t);
    bus.yaw_mag     = 8'(y);
    bus.track_valid = tv;
  endtask

  task automatic push(input int w0, input int w1, input int w2, input int w3, input bit fs);
    frame_exp_t e;
    e.w[0] = 12'(w0);
    e.w[1] = 12'(w1);
    e.w[2] = 12'(w2);
    e.w[3] = 12'(w3);
    e.fs   = fs;
    exp_q.push_back(e);
    $display("plan: slots %0d/%0d/%0d/%0d us, failsafe %0d", w0, w1, w2, w3, fs);
  endtask

  // Returns just after the latch edge that closes the frame_start cycle.
  task automatic wait_fs(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < FRAME_CLK + 100 && !seen; n++) begin
      @(negedge clock);
      if (bus.frame_start === 1'b1) seen = 1'b1;
    end
    if (!seen) abort(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_chan(input int ch, input bit want_high, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < FRAME_CLK && !seen; n++) begin
      @(negedge clock);
      if (bus.chan_idx === 2'(ch) && (!want_high || bus.ppm_out === 1'b1)) seen = 1'b1;
    end
    if (!seen) abort(tag);
  endtask

  // Monitor: one expected record per frame, checked against measured edges.
  initial begin
    mon_cyc       = 0;
    mon_last_fall = 0;
    mon_nfall     = 0;
    mon_frame_no  = 0;
    mon_in_frame  = 1'b0;
    mon_prev_ppm  = 1'bx;
    mon_cur       = '0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        mon_in_frame = 1'b0;
      end else if (bus.frame_start === 1'b1) begin
        if (mon_in_frame) begin
          check("frame_len", mon_cyc + 1, FRAME_CLK);
          check("fall_count", mon_nfall, 4);
          $display("frame %0d measured: %0d falling edges, %0d clocks", mon_frame_no, mon_nfall, mon_cyc + 1);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got a frame_start, expected none queued");
          mon_cur = '0;
        end else begin
          mon_cur = exp_q.pop_front();
        end
        check("start_ppm", int'(bus.ppm_out), 0);
        check("start_chan", int'(bus.chan_idx), 0);
        mon_cyc       = 0;
        mon_last_fall = 0;
        mon_nfall     = 0;
        mon_in_frame  = 1'b1;
        mon_frame_no++;
      end else if (mon_in_frame) begin
        mon_cyc++;
        if (mon_cyc == 1) check("failsafe", int'(bus.failsafe), int'(mon_cur.fs));
        if (mon_prev_ppm === 1'b1 && bus.ppm_out === 1'b0) begin
          mon_nfall++;
          if (mon_nfall <= 4) begin
            check("slot_w", mon_cyc - mon_last_fall, CLK_PER_US * int'(mon_cur.w[mon_nfall - 1]));
            check("fall_chan", int'(bus.chan_idx), (mon_nfall == 4) ? 3 : mon_nfall);
          end else begin
            check("extra_fall", mon_nfall, 4);
          end
          mon_last_fall = mon_cyc;
        end else if (mon_prev_ppm === 1'b0 && bus.ppm_out === 1'b1) begin
          check("sep_len", mon_cyc - mon_last_fall, CLK_PER_US * SEP_US);
        end
      end
      mon_prev_ppm = bus.ppm_out;
    end
  end

  initial begin
    set_in(116, 116, 116, 116, 1'b1);
    reset = 1'b1;
    push(1464, 1464, 1464, 1464, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    check("rst_ppm", int'(bus.ppm_out), 1);
    check("rst_fstart", int'(bus.frame_start), 0);
    check("rst_chan", int'(bus.chan_idx), 0);
    check("rst_failsafe", int'(bus.failsafe), 0);
    reset = 1'b0;
    wait_fs("frame1");

    // Clamped and unclamped values; roll changes mid-frame during channel 1.
    set_in(0, 255, 250, 128, 1'b1);
    push(1000, 2000, 2000, 1512, 1'b0);
    wait_fs("frame2");
    wait_chan(1, 1'b0, "chan1");
    @(posedge clock);
    #1;
    bus.roll_mag = 8'd200;
    push(1800, 2000, 2000, 1512, 1'b0);
    wait_fs("frame3");

    // 24 untracked frames then one tracked frame: counter clears, no failsafe.
    set_in(50, 60, 70, 80, 1'b0);
    for (int i = 0; i < 24; i++) begin
      push(1200, 1240, 1280, 1320, 1'b0);
      wait_fs("low24");
    end
    bus.track_valid = 1'b1;
    push(1200, 1240, 1280, 1320, 1'b0);
    wait_fs("clear");

    // 25 untracked frames: the 25th frame carries substituted values.
    bus.track_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      push(1200, 1240, 1280, 1320, 1'b0);
      wait_fs("low25");
    end
    push(1464, 1464, 1000, 1464, 1'b1);
    wait_fs("fs_on");
    bus.track_valid = 1'b1;
    push(1200, 1240, 1280, 1320, 1'b0);
    wait_fs("recover");

    // One-cycle reset during channel 2 CHAN.
    wait_chan(2, 1'b1, "chan2");
    push(1200, 1240, 1280, 1320, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_rst_ppm", int'(bus.ppm_out), 1);
    check("mid_rst_fstart", int'(bus.frame_start), 0);
    check("mid_rst_chan", int'(bus.chan_idx), 0);
    check("mid_rst_failsafe", int'(bus.failsafe), 0);
    @(posedge clock);
    #1;
    check("post_rst_fstart", int'(bus.frame_start), 1);
    check("post_rst_ppm", int'(bus.ppm_out), 0);
    check("post_rst_chan", int'(bus.chan_idx), 0);
    @(posedge clock);
    #1;
    push(1200, 1240, 1280, 1320, 1'b0);
    wait_fs("final");
    repeat (4) @(posedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
